// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern path: mode encodings, default geometry, colours.
// Mode sequencing depends on VGA_PATTERN_SCROLL_EN (adds MODE_SCROLL to the cycle).
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_t;

  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam int unsigned PIX_W            = 10;
  localparam int unsigned BAR_BITS         = 3;

  localparam logic [2:0] RGB_WHITE = 3'b111;
  localparam logic [2:0] RGB_BLACK = 3'b000;

  function automatic mode_t next_mode(input mode_t m);
    logic [1:0] t;
    t = m + 2'd1;
`ifdef VGA_PATTERN_SCROLL_EN
    next_mode = mode_t'(t);
`else
    next_mode = (m == MODE_GRID) ? MODE_BARS : mode_t'(t);
`endif
  endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// pix/bar counter pair: loadable, advances by STEP pixels, carries into bar at BAR_W, bar wraps at NUM_BARS.
// A load and an advance in the same cycle advance from the loaded value.
module vga_bar_counter
  import vga_pkg::*;
#(
  parameter int unsigned BAR_W    = 80,
  parameter int unsigned NUM_BARS = 8,
  parameter int unsigned STEP     = 1,
  parameter bit          OUT_NEXT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PIX_W-1:0]    load_pix,
  input  logic [BAR_BITS-1:0] load_bar,
  input  logic                adv,
  output logic [PIX_W-1:0]    pix,
  output logic [BAR_BITS-1:0] bar
);

  logic [PIX_W-1:0]    pix_q, cur_pix, next_pix;
  logic [BAR_BITS-1:0] bar_q, cur_bar, next_bar;
  logic [PIX_W:0]      sum;

  always_comb begin
    cur_pix  = load ? load_pix : pix_q;
    cur_bar  = load ? load_bar : bar_q;
    sum      = {1'b0, cur_pix} + (PIX_W+1)'(STEP);
    next_pix = cur_pix;
    next_bar = cur_bar;
    if (adv) begin
      if (sum >= (PIX_W+1)'(BAR_W)) begin
        next_pix = PIX_W'(sum - (PIX_W+1)'(BAR_W));
        next_bar = (cur_bar == BAR_BITS'(NUM_BARS-1)) ? '0 : cur_bar + 1'b1;
      end else begin
        next_pix = sum[PIX_W-1:0];
      end
    end
    // Start-state users need the post-update value; the line counter needs the current one.
    pix = OUT_NEXT ? next_pix : cur_pix;
    bar = OUT_NEXT ? next_bar : cur_bar;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      bar_q <= '0;
    end else begin
      pix_q <= next_pix;
      bar_q <= next_bar;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Runtime-switchable VGA test-pattern generator (bars, checker, grid, optional scrolling bars).
// Define VGA_PATTERN_SCROLL_EN to build the scroll mode and its per-frame start state.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned COLOR_BITS  = 1,
  parameter int unsigned CELL_SHIFT  = 5,
  parameter int unsigned SCROLL_STEP = 2,
  parameter logic        SYNC_IDLE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  valid,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  newline,
  input  logic                  newframe,
  input  logic                  mode_next,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic [1:0]            mode
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
  localparam int unsigned K_MUL = 8 / NUM_BARS;

  if (NUM_BARS < 2 || NUM_BARS > 8 || (NUM_BARS & (NUM_BARS - 1)) != 0 ||
      (H_ACTIVE % NUM_BARS) != 0 || SCROLL_STEP >= BAR_W) begin : g_bad_cfg
    $error("vga_pattern_gen: unsupported parameter combination");
  end

  mode_t mode_q, pending, mode_eff;
  logic  mode_next_q, rise;

  assign rise     = mode_next & ~mode_next_q;
  assign mode_eff = newframe ? pending : mode_q;
  assign mode     = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_BARS;
      pending     <= MODE_BARS;
      mode_next_q <= 1'b0;
    end else begin
      mode_next_q <= mode_next;
      if (newframe) mode_q  <= pending;
      if (rise)     pending <= next_mode(pending);
    end
  end

  logic [PIX_W-1:0]    line_load_pix, pix;
  logic [BAR_BITS-1:0] line_load_bar, bar;

`ifdef VGA_PATTERN_SCROLL_EN
  logic [PIX_W-1:0]    start_pix;
  logic [BAR_BITS-1:0] start_bar;
  logic                start_clear, start_adv;

  assign start_clear = newframe && (mode_q != MODE_SCROLL) && (pending == MODE_SCROLL);
  assign start_adv   = newframe && (mode_q == MODE_SCROLL) && (pending == MODE_SCROLL);

  vga_bar_counter #(
    .BAR_W(BAR_W), .NUM_BARS(NUM_BARS), .STEP(SCROLL_STEP), .OUT_NEXT(1'b1)
  ) u_start (
    .clk(clk), .rst(rst), .load(start_clear), .load_pix('0), .load_bar('0),
    .adv(start_adv), .pix(start_pix), .bar(start_bar)
  );

  assign line_load_pix = (mode_eff == MODE_SCROLL) ? start_pix : '0;
  assign line_load_bar = (mode_eff == MODE_SCROLL) ? start_bar : '0;
`else
  assign line_load_pix = '0;
  assign line_load_bar = '0;
`endif

  vga_bar_counter #(
    .BAR_W(BAR_W), .NUM_BARS(NUM_BARS), .STEP(1), .OUT_NEXT(1'b0)
  ) u_line (
    .clk(clk), .rst(rst), .load(newline), .load_pix(line_load_pix), .load_bar(line_load_bar),
    .adv(valid), .pix(pix), .bar(bar)
  );

  logic [2:0] k, bar_rgb, rgb;
  logic       checker_on, grid_on;

  always_comb begin
    k          = 3'(bar * K_MUL);
    bar_rgb    = {~k[2], ~k[0], ~k[1]};
    checker_on = x[CELL_SHIFT] ^ y[CELL_SHIFT];
    grid_on    = (x[CELL_SHIFT-1:0] == '0) || (y[CELL_SHIFT-1:0] == '0) ||
                 (x == 10'(H_ACTIVE - 1)) || (y == 10'(V_ACTIVE - 1));
    case (mode_eff)
      MODE_BARS:    rgb = bar_rgb;
      MODE_CHECKER: rgb = checker_on ? RGB_WHITE : RGB_BLACK;
      MODE_GRID:    rgb = grid_on ? RGB_WHITE : RGB_BLACK;
      default:      rgb = bar_rgb;
    endcase
    if (!valid) rgb = RGB_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hs_out <= SYNC_IDLE;
      vs_out <= SYNC_IDLE;
    end else begin
      r      <= {COLOR_BITS{rgb[2]}};
      g      <= {COLOR_BITS{rgb[1]}};
      b      <= {COLOR_BITS{rgb[0]}};
      hs_out <= hsync;
      vs_out <= vsync;
    end
  end

endmodule
